// File: rtl/test_i3983_rst.sv
// Self-running reference stimulus: an 8-bit maximal-length Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1) driving one registered pseudo-random output bit.
module test_i3983_rst (
  input  logic CK,
  input  logic reset,
  output logic output_single
);

  localparam logic [7:0] SEED = 8'h01;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       out_q;
  logic       out_d;

  function automatic logic lfsr_feedback(input logic [7:0] s);
    return s[7] ^ s[5] ^ s[4] ^ s[3];
  endfunction

  // All-zero is the LFSR's fixed point; an upset landing there is steered back to the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    out_d  = out_q;
    if (lfsr_q == 8'h00) begin
      lfsr_d = SEED;
      out_d  = 1'b0;
    end else begin
      lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
      out_d  = lfsr_q[7] ^ lfsr_q[0];
    end
  end

  // State and output registers; reset asserts without waiting for a clock.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
      out_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
    end
  end

  assign output_single = out_q;

endmodule

// File: tb/tb_test_i3983_rst.sv
// Self-checking bench for test_i3983_rst: fixed reference traces plus a
// polynomial-level model of the LFSR driven by randomized run/reset timing.
module tb_test_i3983_rst;

  logic CK;
  logic reset;
  logic output_single;

  int checks;
  int errors;

  // Reference model state (integer arithmetic, taps mask 0xB8 = bits 7,5,4,3).
  int m_state;
  int m_out;

  int exp_out [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp_lfsr[9] = '{'h02, 'h04, 'h08, 'h11, 'h23, 'h47, 'h8E, 'h1C, 'h38};

  test_i3983_rst dut (
    .CK           (CK),
    .reset        (reset),
    .output_single(output_single)
  );

  initial CK = 1'b0;
  always #10 CK = ~CK;

  function automatic void model_reset();
    m_state = 1;
    m_out   = 0;
  endfunction

  function automatic void model_step();
    int nxt;
    if (m_state == 0) begin
      m_state = 1;
      m_out   = 0;
    end else begin
      m_out   = ((m_state >> 7) ^ m_state) & 1;
      nxt     = (m_state * 2) % 256;
      m_state = nxt + ($countones(m_state & 'hB8) % 2);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      checks++;
      if (output_single !== 1'b0) begin
        errors++;
        $display("FAIL reset_out cycle %0d: got %b expected 0", i, output_single);
      end
      checks++;
      if (dut.lfsr_q !== 8'h01) begin
        errors++;
        $display("FAIL reset_lfsr cycle %0d: got %h expected 01", i, dut.lfsr_q);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_startup();
    for (int i = 0; i < 9; i++) begin
      @(negedge CK);
      model_step();
      checks++;
      if (output_single !== 1'(exp_out[i])) begin
        errors++;
        $display("FAIL startup_out edge %0d: got %b expected %0d", i + 1, output_single, exp_out[i]);
      end
      checks++;
      if (dut.lfsr_q !== 8'(exp_lfsr[i]) || m_state != exp_lfsr[i]) begin
        errors++;
        $display("FAIL startup_lfsr edge %0d: got %h expected %h", i + 1, dut.lfsr_q, exp_lfsr[i]);
      end
    end
  endtask

  task automatic test_period();
    for (int e = 10; e <= 264; e++) begin
      @(negedge CK);
      model_step();
      checks++;
      if (output_single !== 1'(m_out) || dut.lfsr_q !== 8'(m_state)) begin
        errors++;
        $display("FAIL period_model edge %0d: got out=%b lfsr=%h expected out=%0d lfsr=%h",
                 e, output_single, dut.lfsr_q, m_out, m_state);
      end
      if (e == 255) begin
        checks++;
        if (dut.lfsr_q !== 8'h01) begin
          errors++;
          $display("FAIL period_wrap edge 255: got %h expected 01", dut.lfsr_q);
        end
      end
      if (e >= 256) begin
        checks++;
        if (output_single !== 1'(exp_out[e - 256])) begin
          errors++;
          $display("FAIL period_repeat edge %0d: got %b expected %0d", e, output_single, exp_out[e - 256]);
        end
      end
    end
  endtask

  // Assert reset between edges after edge 'run_len', check the asynchronous drop,
  // release and check the restart.
  task automatic reset_mid_run(input int run_len, input int offset_ns, input string tag);
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < run_len; i++) begin
      @(posedge CK);
      model_step();
      #1;
      checks++;
      if (output_single !== 1'(m_out) || dut.lfsr_q !== 8'(m_state)) begin
        errors++;
        $display("FAIL %s_run edge %0d: got out=%b lfsr=%h expected out=%0d lfsr=%h",
                 tag, i + 1, output_single, dut.lfsr_q, m_out, m_state);
      end
    end
    #(offset_ns);
    reset = 1'b0;
    #1;
    checks++;
    if (output_single !== 1'b0 || dut.lfsr_q !== 8'h01) begin
      errors++;
      $display("FAIL %s_async: got out=%b lfsr=%h expected out=0 lfsr=01", tag, output_single, dut.lfsr_q);
    end
    @(negedge CK);
    @(negedge CK);
    checks++;
    if (output_single !== 1'b0 || dut.lfsr_q !== 8'h01) begin
      errors++;
      $display("FAIL %s_hold: got out=%b lfsr=%h expected out=0 lfsr=01", tag, output_single, dut.lfsr_q);
    end
    reset = 1'b1;
    @(negedge CK);
    checks++;
    if (output_single !== 1'b1 || dut.lfsr_q !== 8'h02) begin
      errors++;
      $display("FAIL %s_restart: got out=%b lfsr=%h expected out=1 lfsr=02", tag, output_single, dut.lfsr_q);
    end
  endtask

  task automatic test_async_reset();
    reset_mid_run(6, 5, "async_reset");
  endtask

  task automatic test_random_resets();
    for (int k = 0; k < 6; k++) begin
      reset_mid_run(int'($urandom_range(300, 1)), int'($urandom_range(8, 1)), "rand_reset");
    end
  endtask

  task automatic test_lockup();
    @(negedge CK);
    force dut.lfsr_q = 8'h00;
    #1;
    release dut.lfsr_q;
    m_state = 0;
    @(negedge CK);
    model_step();
    checks++;
    if (dut.lfsr_q !== 8'h01 || output_single !== 1'b0 || m_state != 1) begin
      errors++;
      $display("FAIL lockup_recover: got lfsr=%h out=%b expected lfsr=01 out=0", dut.lfsr_q, output_single);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge CK);
      model_step();
      checks++;
      if (output_single !== 1'(exp_out[i]) || dut.lfsr_q !== 8'(exp_lfsr[i])) begin
        errors++;
        $display("FAIL lockup_resume step %0d: got out=%b lfsr=%h expected out=%0d lfsr=%h",
                 i + 1, output_single, dut.lfsr_q, exp_out[i], exp_lfsr[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_startup();
    test_period();
    test_async_reset();
    test_random_resets();
    test_lockup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_i3983_rst.md
# test_i3983_rst

Self-running sequential benchmark block (module name `test_i3983_rst`) with no data inputs. It is driven only by clock and reset, and emits a single deterministic pseudo-random bit stream. An 8-bit maximal-length LFSR feeds a registered output bit. The block serves as a fixed-stimulus reference circuit in the benchmark/detection flow, where its output sequence is captured and compared against golden traces.

## Interface
- No parameters; all widths and constants are fixed.
- Clocking: one clock; reset is asynchronous and active-low.
- `CK`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 forces reset state immediately, 1 releases.
- `output_single`  output  1  registered pseudo-random output bit.

## Operation
- Internal state:
  - `lfsr[7:0]`: Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - `out_q`: 1-bit output register.
  - `output_single = out_q`, with no combinational path from any input.
- Reset (`reset`=0):
  - `lfsr` = 8'h01 and `out_q` = 0, asynchronously.
  - Both hold while reset is asserted.
- Each rising `CK` edge with `reset`=1, using the pre-edge `lfsr` value:
  - feedback `fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]`.
  - `lfsr <= {lfsr[6:0], fb}`.
  - `out_q <= lfsr[7] ^ lfsr[0]`.
- Lock-up guard: if `lfsr` is ever 8'h00, the next edge loads 8'h01 instead of shifting, and `out_q` <= 0. This state is unreachable in normal operation; the guard is required for robustness against upsets.
- The sequence is periodic with period 255 cycles. It returns to 8'h01 exactly 255 edges after reset release.
- Reference state sequence from reset:
  - 01, 02, 04, 08, 11, 23, 47, 8E, 1C, …

## Timing
- Output latency: `output_single` reflects the state from one cycle earlier, i.e. one-cycle registered latency.
- Reset is asynchronous on assertion: outputs go to reset values without waiting for a clock edge.
- Reset release: the first rising edge with `reset`=1 performs the first update. There is no release synchronizer inside the block; release must meet recovery/removal timing at the system level.
- Reset asserted mid-sequence: the block immediately returns to `lfsr`=01 and `out_q`=0. After release, the sequence restarts from the beginning.
- Edge coincident with reset assertion: reset wins.
- Output is stable from clock-to-q after the rising edge until the next rising edge.

## Test plan
- Reset check: hold `reset`=0 for several clock cycles → `output_single`=0 throughout, and internal `lfsr`=8'h01.
- Startup sequence: release reset, then sample 10 ns after each of the first 9 rising edges → `output_single` = 1,0,0,0,1,1,1,1,0.
- LFSR trace: after the same 9 edges, `lfsr` = 02,04,08,11,23,47,8E,1C,38.
- Period check: run 255 edges after release → `lfsr` = 8'h01. The output pattern of edges 256–264 repeats 1,0,0,0,1,1,1,1,0.
- Async reset mid-run: assert `reset`=0 between clock edges after edge 6 → `output_single` drops to 0 before the next edge. After release, the first edge gives 1, restarting the sequence.
- Lock-up guard: force `lfsr`=8'h00 via a backdoor → on the next edge, `lfsr`=8'h01 and `output_single`=0, then the normal sequence continues.
